dmem_arbiter: RTL and testbench

Shares the single-port 16-bit data memory between the CPU memory stage and the NN accelerator's load/store engine. Each cycle it picks one owner, muxes that owner's address, write enable and write data onto the memory port, and routes read data back with a one-cycle valid. The CPU has priority by default; the NN engine is granted fixed-length bursts. The CPU pipeline is frozen through `cpu_stall` while it is locked out.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter_burst_counter.sv | 50 +++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter slice.
// Imported by the arbiter top and its interface users.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE,
      NN_BURST
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_NN
   } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, NN engine and memory-port bundle of the arbiter.
// slave = arbiter side, master = requestors plus memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 8
);
   localparam int LEN_W = $clog2(MAX_BURST) + 1;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              nn_req;
   logic              nn_we;
   logic [ADDR_W-1:0] nn_addr;
   logic [DATA_W-1:0] nn_wdata;
   logic [LEN_W-1:0]  nn_burst_len;
   logic              nn_gnt;
   logic [DATA_W-1:0] nn_rdata;
   logic              nn_rvalid;
   logic              nn_done;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      input  nn_req, nn_we, nn_addr, nn_wdata, nn_burst_len,
      output nn_gnt, nn_rdata, nn_rvalid, nn_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      output nn_req, nn_we, nn_addr, nn_wdata, nn_burst_len,
      input  nn_gnt, nn_rdata, nn_rvalid, nn_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_burst_counter.sv
// NN burst length clamp and remaining-beat counter.
// last is valid in the cycle of the granted beat.
module burst_counter #(
   parameter int MAX_BURST = 8,
   parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   input  logic             beat,
   input  logic             abort,
   output logic             last,
   output logic             active
);

   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] eff;

   always_comb begin
      eff = len;
      if (len == '0)
         eff = LEN_W'(1);
      else if (len > LEN_W'(MAX_BURST))
         eff = LEN_W'(MAX_BURST);
   end

   // Counter holds beats still owed after the current one
   always_comb begin
      cnt_d = cnt_q;
      if (abort)
         cnt_d = '0;
      else if (load)
         cnt_d = eff - LEN_W'(1);
      else if (beat && cnt_q != '0)
         cnt_d = cnt_q - LEN_W'(1);
   end

   assign last   = load ? (eff == LEN_W'(1))
                        : (cnt_q == LEN_W'(1));
   assign active = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, NN bursts.
// DMEM_ARB_STARVE_EN adds NN starvation protection.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MAX_BURST  = 8,
   parameter int STARVE_LIM = 4
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);

   localparam int LEN_W = $clog2(MAX_BURST) + 1;

   arb_state_t state_q, state_d;
   arb_owner_t tag_q, tag_d;

   logic cpu_gnt, nn_gnt, starve;
   logic load, beat, abort, last, active;

`ifdef DMEM_ARB_STARVE_EN
   localparam int WAIT_W = $clog2(STARVE_LIM) + 1;

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              starve_q, starve_d;

   always_comb begin
      wait_d   = wait_q;
      starve_d = starve_q;
      if (nn_gnt) begin
         wait_d   = '0;
         starve_d = 1'b0;
      end else if (bus.nn_req && !starve_q) begin
         wait_d = wait_q + WAIT_W'(1);
         if (wait_d == WAIT_W'(STARVE_LIM))
            starve_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_q   <= '0;
         starve_q <= 1'b0;
      end else begin
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   assign starve = starve_q;
`else
   assign starve = 1'b0;
`endif

   // Grants are gated by reset so outputs sit at reset values
   always_comb begin
      cpu_gnt = 1'b0;
      nn_gnt  = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               nn_gnt  = bus.nn_req & (~bus.cpu_req | starve);
               cpu_gnt = bus.cpu_req & ~nn_gnt;
            end
            NN_BURST: nn_gnt = bus.nn_req;
         endcase
      end
   end

   assign load  = nn_gnt & ~active;
   assign beat  = nn_gnt & active;
   assign abort = (state_q == NN_BURST) & ~bus.nn_req;

   burst_counter #(
      .MAX_BURST (MAX_BURST),
      .LEN_W     (LEN_W)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .len    (bus.nn_burst_len),
      .beat   (beat),
      .abort  (abort),
      .last   (last),
      .active (active)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (load && !last) state_d = NN_BURST;
         NN_BURST: if (abort || last) state_d = IDLE;
      endcase
   end

   always_comb begin
      tag_d = OWN_NONE;
      if (cpu_gnt && !bus.cpu_we)
         tag_d = OWN_CPU;
      else if (nn_gnt && !bus.nn_we)
         tag_d = OWN_NN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tag_q   <= OWN_NONE;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

   always_comb begin
      bus.mem_en    = cpu_gnt | nn_gnt;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (cpu_gnt) begin
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (nn_gnt) begin
         bus.mem_we    = bus.nn_we;
         bus.mem_addr  = bus.nn_addr;
         bus.mem_wdata = bus.nn_wdata;
      end
   end

   assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
   assign bus.nn_gnt     = nn_gnt;
   assign bus.nn_done    = nn_gnt & last;
   assign bus.cpu_rvalid = rst_n & (tag_q == OWN_CPU);
   assign bus.nn_rvalid  = rst_n & (tag_q == OWN_NN);
   assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
   assign bus.nn_rdata   = bus.nn_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus
// starvation and mid-burst reset sequences.
module tb_dmem_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct packed {
      logic        creq, cwe;
      logic [15:0] caddr, cwd;
      logic        nreq, nwe;
      logic [15:0] naddr, nwd;
      logic [3:0]  nlen;
   } stim_t;

   typedef struct packed {
      logic        stall, ngnt, ndone, men, mwe;
      logic [15:0] maddr, mwd;
      logic        crv;
      logic [15:0] crd;
      logic        nrv;
      logic [15:0] nrd;
   } obs_t;

   typedef struct {
      stim_t s;
      obs_t  e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl [27];

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory: 0x0010 holds 0x1234, every other word {C0, addr[7:0]}
   always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we)
         bus.mem_rdata <= (bus.mem_addr == 16'h0010) ? 16'h1234
                          : {8'hC0, bus.mem_addr[7:0]};
   end

   function automatic stim_t st(
      input logic cr, cw, input logic [15:0] ca, cd,
      input logic nr, nw, input logic [15:0] na, nd,
      input logic [3:0] nl);
      return '{cr, cw, ca, cd, nr, nw, na, nd, nl};
   endfunction

   function automatic obs_t ob(
      input logic s, g, d, me, mw,
      input logic [15:0] ma, md,
      input logic cv, input logic [15:0] cdat,
      input logic nv, input logic [15:0] ndat);
      return '{s, g, d, me, mw, ma, md, cv, cdat, nv, ndat};
   endfunction

   task automatic drive(input stim_t s);
      bus.cpu_req      = s.creq;
      bus.cpu_we       = s.cwe;
      bus.cpu_addr     = s.caddr;
      bus.cpu_wdata    = s.cwd;
      bus.nn_req       = s.nreq;
      bus.nn_we        = s.nwe;
      bus.nn_addr      = s.naddr;
      bus.nn_wdata     = s.nwd;
      bus.nn_burst_len = s.nlen;
   endtask

   task automatic check(input string name, input obs_t e);
      obs_t a;
      a = '{bus.cpu_stall, bus.nn_gnt, bus.nn_done,
            bus.mem_en, bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.cpu_rvalid, bus.cpu_rdata,
            bus.nn_rvalid, bus.nn_rdata};
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic step(input stim_t s);
      @(posedge clk);
      #1;
      drive(s);
      @(negedge clk);
   endtask

   initial begin
      stim_t idle;
      obs_t  zero;
      logic  exp_g;
      idle = st(L, L, 16'h0, 16'h0, L, L, 16'h0, 16'h0, 4'd0);
      zero = '0;

      tbl[0]  = '{st(H, L, 16'h10, 16'h0, L, L, 16'h0, 16'h0, 4'd0),
                  ob(L, L, L, H, L, 16'h10, 16'h0, L, 16'h0, L, 16'h0)};
      tbl[1]  = '{idle,
                  ob(L, L, L, L, L, 16'h0, 16'h0, H, 16'h1234, L, 16'h0)};
      tbl[2]  = '{st(L, L, 16'h0, 16'h0, H, L, 16'h20, 16'h0, 4'd4),
                  ob(L, H, L, H, L, 16'h20, 16'h0, L, 16'h0, L, 16'h0)};
      tbl[3]  = '{st(H, L, 16'h11, 16'h0, H, L, 16'h21, 16'h0, 4'd4),
                  ob(H, H, L, H, L, 16'h21, 16'h0, L, 16'h0, H, 16'hC020)};
      tbl[4]  = '{st(H, L, 16'h11, 16'h0, H, L, 16'h22, 16'h0, 4'd4),
                  ob(H, H, L, H, L, 16'h22, 16'h0, L, 16'h0, H, 16'hC021)};
      tbl[5]  = '{st(H, L, 16'h11, 16'h0, H, L, 16'h23, 16'h0, 4'd4),
                  ob(H, H, H, H, L, 16'h23, 16'h0, L, 16'h0, H, 16'hC022)};
      tbl[6]  = '{st(H, L, 16'h11, 16'h0, L, L, 16'h0, 16'h0, 4'd0),
                  ob(L, L, L, H, L, 16'h11, 16'h0, L, 16'h0, H, 16'hC023)};
      tbl[7]  = '{idle,
                  ob(L, L, L, L, L, 16'h0, 16'h0, H, 16'hC011, L, 16'h0)};
      tbl[8]  = '{st(H, H, 16'h30, 16'hBEEF, H, L, 16'h40, 16'h0, 4'd1),
                  ob(L, L, L, H, H, 16'h30, 16'hBEEF, L, 16'h0, L, 16'h0)};
      tbl[9]  = '{st(L, L, 16'h0, 16'h0, H, H, 16'h40, 16'h5555, 4'd1),
                  ob(L, H, H, H, H, 16'h40, 16'h5555, L, 16'h0, L, 16'h0)};
      tbl[10] = '{idle, zero};
      tbl[11] = '{st(L, L, 16'h0, 16'h0, H, L, 16'h50, 16'h0, 4'd0),
                  ob(L, H, H, H, L, 16'h50, 16'h0, L, 16'h0, L, 16'h0)};
      tbl[12] = '{idle,
                  ob(L, L, L, L, L, 16'h0, 16'h0, L, 16'h0, H, 16'hC050)};
      for (int k = 0; k < 8; k++)
         tbl[13+k] = '{st(L, L, 16'h0, 16'h0, H, L, 16'h60 + 16'(k),
                          16'h0, 4'd15),
                       ob(L, H, logic'(k == 7), H, L, 16'h60 + 16'(k),
                          16'h0, L, 16'h0, logic'(k > 0),
                          (k > 0) ? 16'hC060 + 16'(k - 1) : 16'h0)};
      tbl[21] = '{idle,
                  ob(L, L, L, L, L, 16'h0, 16'h0, L, 16'h0, H, 16'hC067)};
      tbl[22] = '{st(L, L, 16'h0, 16'h0, H, L, 16'h70, 16'h0, 4'd6),
                  ob(L, H, L, H, L, 16'h70, 16'h0, L, 16'h0, L, 16'h0)};
      tbl[23] = '{st(L, L, 16'h0, 16'h0, H, L, 16'h71, 16'h0, 4'd6),
                  ob(L, H, L, H, L, 16'h71, 16'h0, L, 16'h0, H, 16'hC070)};
      tbl[24] = '{st(H, L, 16'h12, 16'h0, L, L, 16'h0, 16'h0, 4'd0),
                  ob(H, L, L, L, L, 16'h0, 16'h0, L, 16'h0, H, 16'hC071)};
      tbl[25] = '{st(H, L, 16'h12, 16'h0, L, L, 16'h0, 16'h0, 4'd0),
                  ob(L, L, L, H, L, 16'h12, 16'h0, L, 16'h0, L, 16'h0)};
      tbl[26] = '{idle,
                  ob(L, L, L, L, L, 16'h0, 16'h0, H, 16'hC012, L, 16'h0)};

      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in_reset", zero);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset", zero);

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].s);
         check($sformatf("vec%0d", i), tbl[i].e);
      end

      // CPU held against a waiting NN for 10 cycles
      for (int c = 0; c < 10; c++) begin
         step(st(H, L, 16'h13, 16'h0, H, L, 16'h80, 16'h0, 4'd1));
`ifdef DMEM_ARB_STARVE_EN
         exp_g = (c == 4) || (c == 9);
`else
         exp_g = 1'b0;
`endif
         n_vec++;
         if (bus.nn_gnt !== exp_g || bus.cpu_stall !== exp_g) begin
            n_bad++;
            $display("FAIL starve%0d: gnt=%b stall=%b expected %b",
                     c, bus.nn_gnt, bus.cpu_stall, exp_g);
         end
      end
      step(idle);

      // Reset pulse in the cycle after an NN read grant
      step(st(L, L, 16'h0, 16'h0, H, L, 16'h90, 16'h0, 4'd4));
      check("rst_burst_gnt",
            ob(L, H, L, H, L, 16'h90, 16'h0, L, 16'h0, L, 16'h0));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(st(L, L, 16'h0, 16'h0, H, L, 16'h91, 16'h0, 4'd4));
      @(negedge clk);
      check("rst_mid_burst", zero);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(st(H, L, 16'h14, 16'h0, H, L, 16'h91, 16'h0, 4'd1));
      @(negedge clk);
      check("rst_idle_cpu",
            ob(L, L, L, H, L, 16'h14, 16'h0, L, 16'h0, L, 16'h0));
      step(idle);
      check("rst_cpu_rd",
            ob(L, L, L, L, L, 16'h0, 16'h0, H, 16'hC014, L, 16'h0));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
